dmem_resp: RTL

Data-memory responder: the target side of the core's load/store port. Accepts one request at a time over a valid/ready channel, applies a programmable number of wait states, and commits a byte-lane write or returns a byte/half/word read. Reads are right-justified and zero- or sign-extended. Used wherever the core's data port is served by a latency-bearing memory instead of an ideal single-cycle array.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/dmem_lane_align.sv | 71 +++++++
 rtl/dmem_resp.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the core's load/store path.
//   - t_dmem_state : responder FSM states (IDLE, WAIT, RESP)
//   - t_dmem_req   : one latched load/store request
//   - BE_BYTE / BE_HALF / BE_WORD : legal size masks on req_byt_en
//   - be_size()    : access size in bytes for a legal mask, 0 otherwise
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } t_dmem_state;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr_en;
        logic [3:0]  byt_en;
        logic        sign_ext;
        logic [31:0] wr_data;
    } t_dmem_req;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [2:0] be_size(input logic [3:0] be);
        case (be)
            BE_BYTE: be_size = 3'd1;
            BE_HALF: be_size = 3'd2;
            BE_WORD: be_size = 3'd4;
            default: be_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
//   Combinational byte-lane steering for a 32-bit data port.
//   Optional feature macro: DMEM_RESP_MISALIGN_CHK_EN (flags illegal masks and
//   accesses that cross the word boundary; without it illegal is tied to 0).
// Ports:
//   offset    in   byte offset within the word (addr[1:0])
//   byt_en    in   size mask, right-justified
//   sign_ext  in   sign-extend load result
//   wr_data   in   store data, right-justified
//   rd_word   in   raw word read from the array
//   lane_mask out  byte lanes to write (mask shifted up, lanes past 3 dropped)
//   wr_word   out  store data placed onto its lanes
//   rd_data   out  load data shifted down and zero/sign extended
//   illegal   out  request violates size/alignment rules
// ----------------------------------------------------------------------------
module dmem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [3:0]  byt_en,
    input  logic        sign_ext,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  lane_mask,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data,
    output logic        illegal
);

    logic [31:0] shifted;
    logic [1:0]  top;
    logic        fill;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        lane_mask = byt_en << offset;
        wr_word   = wr_data << {offset, 3'b000};
        shifted   = rd_word >> {offset, 3'b000};

        // Highest enabled byte supplies the sign for the fill above it.
        top = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (byt_en[i]) top = 2'(i);
        end
        fill = sign_ext & (|byt_en) & shifted[{top, 3'b111}];

        rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (byt_en[i])
                rd_data[8*i +: 8] = shifted[8*i +: 8];
            else if (2'(i) > top)
                rd_data[8*i +: 8] = {8{fill}};
        end
    end

`ifdef DMEM_RESP_MISALIGN_CHK_EN
    always_comb begin
        case (byt_en)
            BE_BYTE: illegal = 1'b0;
            BE_HALF: illegal = (offset == 2'd3);
            BE_WORD: illegal = (offset != 2'd0);
            default: illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/dmem_resp.sv
// ----------------------------------------------------------------------------
// dmem_resp
//   Data-memory responder: accepts one load/store at a time, waits LATENCY
//   cycles, accesses a MEM_WORDS x 32 array, and returns one response.
//   Optional feature macro: DMEM_RESP_MISALIGN_CHK_EN (illegal requests write
//   nothing and respond with rsp_err=1, rsp_rd_data=0).
// Parameters:
//   MEM_WORDS  array depth in words (power of two, >= 2)
//   LATENCY    wait states between accept and array access (0..15)
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req_valid/ready request handshake
//   req_addr        byte address (wraps modulo MEM_WORDS words)
//   req_wr_en       1 = store, 0 = load
//   req_byt_en      size mask 0001/0011/1111
//   req_sign_ext    sign-extend load result
//   req_wr_data     store data, right-justified
//   rsp_valid/ready response handshake
//   rsp_rd_data     load result, 0 for stores
//   rsp_err         illegal request indication
// ----------------------------------------------------------------------------
module dmem_resp
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr_en,
    input  logic [3:0]  req_byt_en,
    input  logic        req_sign_ext,
    input  logic [31:0] req_wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_err
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [3:0]  WCNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam t_dmem_state ACC_STATE = (LATENCY == 0) ? RESP : WAIT;

    t_dmem_state      state, next_state;
    logic [3:0]       wcnt;
    t_dmem_req        req_in, req_q, acc_req;
    logic             accept, access;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      rd_word, wr_word, ld_data;
    logic [3:0]       lane_mask;
    logic             illegal;
    logic             unused_addr_hi;

    logic [31:0] mem [MEM_WORDS];

    assign req_in = '{addr: req_addr, wr_en: req_wr_en, byt_en: req_byt_en,
                      sign_ext: req_sign_ext, wr_data: req_wr_data};

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = ACC_STATE;
            end
            WAIT: begin
                if (wcnt == 4'd0) next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) next_state = req_valid ? ACC_STATE : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = req_valid & req_ready;

    // With zero latency the array is touched on the accept edge itself, so the
    // live request is used; otherwise the latched copy drives the access.
    assign access  = (LATENCY == 0) ? accept : (state == WAIT && wcnt == 4'd0);
    assign acc_req = (state == WAIT) ? req_q : req_in;
    assign acc_idx = acc_req.addr[IDX_W+1:2];
    assign rd_word = mem[acc_idx];

    // Address bits above the array index wrap and are deliberately ignored.
    assign unused_addr_hi = ^acc_req.addr[31:IDX_W+2];

    dmem_lane_align u_align (
        .offset    (acc_req.addr[1:0]),
        .byt_en    (acc_req.byt_en),
        .sign_ext  (acc_req.sign_ext),
        .wr_data   (acc_req.wr_data),
        .rd_word   (rd_word),
        .lane_mask (lane_mask),
        .wr_word   (wr_word),
        .rd_data   (ld_data),
        .illegal   (illegal)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wcnt        <= 4'd0;
            req_q       <= '0;
            rsp_rd_data <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_q <= req_in;
                wcnt  <= WCNT_LOAD;
            end else if (state == WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (access) begin
                rsp_rd_data <= (acc_req.wr_en || illegal) ? 32'd0 : ld_data;
                rsp_err     <= illegal;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation and contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        if (access && acc_req.wr_en && !illegal) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_mask[k]) mem[acc_idx][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

endmodule
